result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-002 rst input 1 SHALL be the synchronous active-high reset, sampled only on clk rising edge.
REQ-003 in_data input 32 SHALL carry the 32-bit selected operand from the upstream 4:1 mux output.
REQ-004 in_sel input 2 SHALL carry the mux select value that produced in_data, buffered alongside it as a tag.
REQ-005 in_valid input 1 SHALL indicate that in_data/in_sel hold a result to capture.
REQ-006 in_ready output 1 SHALL indicate that the buffer can accept an entry this cycle.
REQ-007 out_data output 32 SHALL present the head entry's data.
REQ-008 out_sel output 2 SHALL present the head entry's tag.
REQ-009 out_valid output 1 SHALL be high when the buffer holds at least one entry.
REQ-010 out_ready input 1 SHALL indicate that the consumer accepts the head entry.
REQ-011 count output 2 SHALL report occupancy, 0..2.
REQ-012 out_zero output 1 and out_neg output 1 SHALL exist only when RESULT_FLAGS_EN is defined.

Function
REQ-013 The block SHALL be a 2-entry in-order FIFO of {in_data, in_sel}.
REQ-014 A push SHALL occur on a clk edge where in_valid and in_ready are both high.
REQ-015 A pop SHALL occur on a clk edge where out_valid and out_ready are both high.
REQ-016 in_ready SHALL equal (count < 2), derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0).
REQ-018 Latency SHALL be one cycle: data pushed at edge N into an empty buffer SHALL appear on out_data with out_valid high in the cycle following edge N.
REQ-019 While out_valid is high and out_ready is low, out_data, out_sel and the flags SHALL stay stable.
REQ-020 If push and pop occur together at count==1, count SHALL stay 1 and the new entry SHALL become head after the edge.
REQ-021 At count==2, no push SHALL occur (in_ready low); a pop SHALL reduce count to 1 and advance the second entry to head.
REQ-022 At count==0, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-023 At count==0, out_data and out_sel SHALL retain their last driven values.
REQ-024 Entries SHALL be stored bit-exact, with no arithmetic applied to data.

Reset
REQ-025 When rst is high at a clk edge, count SHALL become 0, out_valid 0, in_ready 1, out_data 32'h0, out_sel 2'b00, and out_zero/out_neg 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; a push coincident with rst SHALL be dropped.
REQ-027 Reset SHALL take priority over push and pop on the same edge.

Configuration
REQ-028 When macro RESULT_FLAGS_EN is defined, out_zero SHALL be (head data == 0) and out_neg SHALL be head data bit 31, both computed at push time and stored with the entry.
REQ-029 Without RESULT_FLAGS_EN, the out_zero/out_neg ports and their storage SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset check: assert rst for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_data=0.
REQ-031 Single pass-through: push 32'hDEADBEEF with sel=2'b10 and out_ready=1 -> next cycle out_data=DEADBEEF, out_sel=10, out_valid=1; after the pop, count=0.
REQ-032 Fill and back-pressure: with out_ready=0, push 32'h1 then 32'h2, and hold in_valid with 32'h3 -> count=2, in_ready=0, out_data=1, and 32'h3 is never stored.
REQ-033 Drain order: from the full state, set out_ready=1 -> out_data shows 1 then 2, count goes 2->1->0, and out_valid drops.
REQ-034 Simultaneous push and pop at count=1 (head 32'hA, push 32'hB) -> count stays 1 and the next head is 32'hB.
REQ-035 Flags (RESULT_FLAGS_EN): push 32'h0 then 32'h80000000 -> out_zero=1/out_neg=0, then out_zero=0/out_neg=1; separately, assert rst while count=2 -> count=0 on the next cycle.

Source files
------------

// File: rtl/result_buffer.sv
//------------------------------------------------------------------------------
// Module  : result_buffer
// Brief   : Two-entry in-order buffer of {data, select tag} for a 4:1 mux
//           result. RESULT_FLAGS_EN adds stored zero/negative flags.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef RESULT_FLAGS_EN
  output logic        out_zero,
  output logic        out_neg,
`endif
  output logic [1:0]  count
);

  localparam logic [1:0] c_DEPTH = 2'd2;
`ifdef RESULT_FLAGS_EN
  localparam int c_EW = 36;
`else
  localparam int c_EW = 34;
`endif

  logic [c_EW-1:0] r_head;
  logic [c_EW-1:0] r_tail;
  logic [1:0]      r_count;
  logic [c_EW-1:0] w_in_entry;
  logic            w_push;
  logic            w_pop;

  // Flags are derived once at capture so the output side is purely registered.
`ifdef RESULT_FLAGS_EN
  assign w_in_entry = {(in_data == 32'h0), in_data[31], in_sel, in_data};
`else
  assign w_in_entry = {in_sel, in_data};
`endif

  assign w_push = in_valid && (r_count < c_DEPTH);
  assign w_pop  = out_ready && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_in_entry;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          // Push with pop replaces the head directly; occupancy is unchanged.
          if (w_push && w_pop) begin
            r_head <= w_in_entry;
          end else if (w_push) begin
            r_tail  <= w_in_entry;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_count < c_DEPTH);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;
  assign out_data  = r_head[31:0];
  assign out_sel   = r_head[33:32];
`ifdef RESULT_FLAGS_EN
  assign out_zero  = r_head[35];
  assign out_neg   = r_head[34];
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_result_buffer
// Brief   : Scoreboard bench for result_buffer with directed and random traffic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  count;
`ifdef RESULT_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
`endif

  result_buffer u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef RESULT_FLAGS_EN
    .out_zero (out_zero),
    .out_neg  (out_neg),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] last_data = 32'h0;
  logic [1:0]  last_sel  = 2'b00;
  int          n_checks  = 0;
  int          n_fail    = 0;
  bit          mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of depth two, updated from the sampled handshake.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_data = 32'h0;
      last_sel  = 2'b00;
    end else begin
      int n;
      entry_t e;
      n = exp_q.size();
      if (n > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && n < 2) begin
        e.data = in_data;
        e.sel  = in_sel;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count",     32'(count),     32'(exp_q.size()));
      chk("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", out_data,      exp_q[0].data);
        chk("out_sel",  32'(out_sel),  32'(exp_q[0].sel));
`ifdef RESULT_FLAGS_EN
        chk("out_zero", 32'(out_zero), 32'(exp_q[0].data == 32'h0));
        chk("out_neg",  32'(out_neg),  32'(exp_q[0].data >= 32'h8000_0000));
`endif
        last_data = exp_q[0].data;
        last_sel  = exp_q[0].sel;
      end else begin
        chk("idle_data", out_data,     last_data);
        chk("idle_sel",  32'(out_sel), 32'(last_sel));
      end
    end
  end

  task automatic step(input logic iv, input logic [31:0] d, input logic [1:0] s,
                      input logic ordy, input logic r);
    in_valid  = iv;
    in_data   = d;
    in_sel    = s;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_sel = 2'b01; out_ready = 1'b0;
    // Reset held two cycles with a pending push that must be dropped.
    step(1'b1, 32'h55, 2'b01, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b1, 32'h55, 2'b01, 1'b0, 1'b1);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Single pass-through.
    step(1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Fill and back-pressure; 3 must never be stored.
    step(1'b1, 32'h1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h2, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'h3, 2'b11, 1'b0, 1'b0);
    step(1'b1, 32'h3, 2'b11, 1'b0, 1'b0);

    // Drain order.
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Simultaneous push and pop at occupancy one.
    step(1'b1, 32'hA, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'hB, 2'b10, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    // Flag patterns, then reset while full.
    step(1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0000, 2'b11, 1'b0, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 32'h7, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'h9, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'hC, 2'b11, 1'b1, 1'b1);
    step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Randomized traffic with occasional resets and corner data values.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'h0;
        1:       d = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
        default: d = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), d, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
